simple_fpga_cvs_core: RTL and testbench

- Clock/signal verification block for FPGA bring-up. Routes five single-ended test signals straight to five output pins.
- Converts the differential 300 MHz oscillator pair to a single-ended output.
- Monitors the oscillator in the system clock domain, reporting activity and an edge count per measurement window.
- Sits at the top level, between the board pins and the pad buffers.

---
 rtl/simple_fpga_cvs_pkg.sv | 13 +
 rtl/simple_fpga_cvs_core_freq_monitor.sv | 58 +++++
 rtl/simple_fpga_cvs_core.sv | 38 +++
 tb/tb_simple_fpga_cvs_core.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_fpga_cvs_pkg.sv
// Shared constants for the FPGA clock/signal verification core.
package simple_fpga_cvs_pkg;

  localparam int unsigned N_CH          = 5;
  localparam int unsigned WINDOW_CYCLES = 65536;
  localparam int unsigned COUNT_W       = 16;
  localparam int unsigned MIN_EDGES     = 1;

  // Bit positions within the differential oscillator pair
  localparam int unsigned OSC_P = 0;
  localparam int unsigned OSC_N = 1;

endpackage

// File: rtl/simple_fpga_cvs_core_freq_monitor.sv
// Oscillator activity monitor: synchronizes a free-running signal and counts its
// rising edges over fixed windows of the system clock.
module freq_monitor #(
  parameter int unsigned WINDOW_CYCLES = 65536,
  parameter int unsigned COUNT_W       = 16,
  parameter int unsigned MIN_EDGES     = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               osc_i,
  output logic               alive_o,
  output logic [COUNT_W-1:0] count_o
);

  localparam int unsigned WcW = $clog2(WINDOW_CYCLES);
  localparam logic [WcW-1:0] WcLast = WcW'(WINDOW_CYCLES - 1);

  // sync_q[0] = s1, sync_q[1] = s2, sync_q[2] = s3
  logic [2:0]         sync_q;
  logic [WcW-1:0]     wc_q;
  logic [COUNT_W-1:0] ec_q;
  logic [COUNT_W-1:0] ec_inc;
  logic [COUNT_W-1:0] count_q;
  logic               alive_q;
  logic               rise;
  logic               win_end;

  always_comb begin
    rise    = sync_q[1] & ~sync_q[2];
    win_end = (wc_q == WcLast);
    // Includes this cycle's edge so an edge on the closing cycle lands in that window
    ec_inc  = (rise && !(&ec_q)) ? ec_q + 1'b1 : ec_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      wc_q    <= '0;
      ec_q    <= '0;
      count_q <= '0;
      alive_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], osc_i};
      wc_q   <= wc_q + 1'b1;
      if (win_end) begin
        count_q <= ec_inc;
        alive_q <= (32'(ec_inc) >= MIN_EDGES);
        ec_q    <= '0;
      end else begin
        ec_q <= ec_inc;
      end
    end
  end

  assign alive_o = alive_q;
  assign count_o = count_q;

endmodule

// File: rtl/simple_fpga_cvs_core.sv
// Top level of the bring-up core: pin pass-through, differential oscillator receiver
// and the oscillator frequency monitor.
module simple_fpga_cvs_core #(
  parameter int unsigned N_CH          = simple_fpga_cvs_pkg::N_CH,
  parameter int unsigned WINDOW_CYCLES = simple_fpga_cvs_pkg::WINDOW_CYCLES,
  parameter int unsigned COUNT_W       = simple_fpga_cvs_pkg::COUNT_W,
  parameter int unsigned MIN_EDGES     = simple_fpga_cvs_pkg::MIN_EDGES
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_CH-1:0]    in_sig,
  output logic [N_CH-1:0]    out,
  input  logic [1:0]         osc_300_pn,
  output logic               osc_300_out,
  output logic               osc_300_alive,
  output logic [COUNT_W-1:0] osc_300_count
);

  import simple_fpga_cvs_pkg::*;

  assign out = in_sig;

  // An invalid pair (P == N) resolves to 0
  assign osc_300_out = osc_300_pn[OSC_P] & ~osc_300_pn[OSC_N];

  freq_monitor #(
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .COUNT_W       (COUNT_W),
    .MIN_EDGES     (MIN_EDGES)
  ) u_freq_monitor (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .osc_i   (osc_300_out),
    .alive_o (osc_300_alive),
    .count_o (osc_300_count)
  );

endmodule

// File: tb/tb_simple_fpga_cvs_core.sv
// Self-checking bench: a windowed DUT (a) and a small saturating DUT (b) share clock/reset;
// a per-cycle sample history of the oscillator drives the expected edge counts.
module tb_simple_fpga_cvs_core;

  localparam int W_A     = 1024;
  localparam int W_B     = 64;
  localparam int MAX_A   = 65535;
  localparam int MAX_B   = 15;

  logic        clock;
  logic        reset_n;
  logic [4:0]  in_sig;
  logic [4:0]  out_a, out_b;
  logic [1:0]  osc_a, osc_b;
  logic        oout_a, oout_b;
  logic        alive_a, alive_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int   n_cmp;
  int   n_err;
  int   n_cyc;
  logic hist[$];
  logic osc_p_state;
  logic [31:0] last_cnt;
  logic        last_alive;

  simple_fpga_cvs_core #(
    .N_CH(5), .WINDOW_CYCLES(W_A), .COUNT_W(16), .MIN_EDGES(1)
  ) u_dut_a (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_sig        (in_sig),
    .out           (out_a),
    .osc_300_pn    (osc_a),
    .osc_300_out   (oout_a),
    .osc_300_alive (alive_a),
    .osc_300_count (cnt_a)
  );

  simple_fpga_cvs_core #(
    .N_CH(5), .WINDOW_CYCLES(W_B), .COUNT_W(4), .MIN_EDGES(1)
  ) u_dut_b (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_sig        (in_sig),
    .out           (out_b),
    .osc_300_pn    (osc_b),
    .osc_300_out   (oout_b),
    .osc_300_alive (alive_b),
    .osc_300_count (cnt_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sample n drives a counted edge at clock n when samples n-2 / n-3 are 1 / 0
  // (the monitor flops hold 0 out of reset, hence 0 before the first sample).
  function automatic int exp_count(int k, int w, int maxv);
    int   c;
    logic a, b;
    c = 0;
    for (int n = k * w; n < k * w + w; n++) begin
      a = (n - 2 >= 0) ? hist[n - 2] : 1'b0;
      b = (n - 3 >= 0) ? hist[n - 3] : 1'b0;
      if (a && !b) c++;
    end
    return (c > maxv) ? maxv : c;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    osc_a   = 2'b10;
    osc_b   = 2'b10;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    n_cyc       = 0;
    hist.delete();
    last_cnt    = '0;
    last_alive  = 1'b0;
    osc_p_state = 1'b0;
  endtask

  // mode 0: square wave, half period hp; 1: dead; 2: random pairs; 3: single rise
  // whose edge reaches the counter on the last cycle of window 0.
  task automatic run_cycles(input int dut, input int mode, input int hp, input int ncyc);
    int          w;
    int          maxv;
    logic [31:0] obs_cnt;
    logic        obs_alive;
    logic [31:0] exp_cnt;
    logic        exp_alive;
    logic [1:0]  pn;
    logic        v;
    w    = dut ? W_B : W_A;
    maxv = dut ? MAX_B : MAX_A;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      obs_cnt   = dut ? 32'(cnt_b) : 32'(cnt_a);
      obs_alive = dut ? alive_b : alive_a;
      if (n_cyc > 0 && n_cyc % w == 0) begin
        exp_cnt   = 32'(exp_count(n_cyc / w - 1, w, maxv));
        exp_alive = (exp_cnt >= 1);
        n_cmp++;
        if (obs_cnt !== exp_cnt || obs_alive !== exp_alive) begin
          n_err++;
          $display("FAIL window_end dut%0d win%0d: count=%0d alive=%b, required count=%0d alive=%b",
                   dut, n_cyc / w - 1, obs_cnt, obs_alive, exp_cnt, exp_alive);
        end
        last_cnt   = exp_cnt;
        last_alive = exp_alive;
      end else if (n_cyc % w == w / 2 || n_cyc % w == w - 1) begin
        n_cmp++;
        if (obs_cnt !== last_cnt || obs_alive !== last_alive) begin
          n_err++;
          $display("FAIL hold dut%0d cyc%0d: count=%0d alive=%b, required count=%0d alive=%b",
                   dut, n_cyc, obs_cnt, obs_alive, last_cnt, last_alive);
        end
      end
      case (mode)
        0: begin
          if (n_cyc % hp == 0) osc_p_state = ~osc_p_state;
          pn = {~osc_p_state, osc_p_state};
        end
        1: pn = 2'b10;
        2: pn = 2'($urandom);
        default: begin
          v  = (n_cyc >= w - 3 && n_cyc < w + 5);
          pn = {~v, v};
        end
      endcase
      if (dut != 0) begin
        osc_b = pn;
        osc_a = 2'b10;
      end else begin
        osc_a = pn;
        osc_b = 2'b10;
      end
      hist.push_back(pn[0] & ~pn[1]);
      n_cyc++;
    end
  endtask

  task automatic test_pass_through();
    for (int i = 0; i < 20; i++) begin
      in_sig = 5'($urandom);
      if (i == 5)  reset_n = 1'b0;
      if (i == 12) reset_n = 1'b1;
      #1;
      n_cmp++;
      if (out_a !== in_sig || out_b !== in_sig) begin
        n_err++;
        $display("FAIL pass_through step%0d: out_a=%b out_b=%b, required %b",
                 i, out_a, out_b, in_sig);
      end
    end
  endtask

  task automatic test_differential();
    logic [1:0] pn_tab[4];
    logic       exp_tab[4];
    pn_tab  = '{2'b01, 2'b10, 2'b00, 2'b11};
    exp_tab = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      osc_a = pn_tab[i];
      osc_b = pn_tab[i];
      #1;
      n_cmp++;
      if (oout_a !== exp_tab[i] || oout_b !== exp_tab[i]) begin
        n_err++;
        $display("FAIL differential P=%b N=%b: out_a=%b out_b=%b, required %b",
                 pn_tab[i][0], pn_tab[i][1], oout_a, oout_b, exp_tab[i]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (cnt_a !== 16'd0 || alive_a !== 1'b0 || cnt_b !== 4'd0 || alive_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: cnt_a=%0d alive_a=%b cnt_b=%0d alive_b=%b, required all 0",
               cnt_a, alive_a, cnt_b, alive_b);
    end
    do_reset();
  endtask

  task automatic test_frequency();
    int hp;
    hp = int'($urandom_range(2, 7));
    do_reset();
    run_cycles(0, 0, hp, 3 * W_A + 1);
    n_cmp++;
    if (32'(cnt_a) + 1 < W_A / (2 * hp) || 32'(cnt_a) > W_A / (2 * hp) + 1 || alive_a !== 1'b1) begin
      n_err++;
      $display("FAIL frequency hp=%0d: count=%0d alive=%b, required %0d(+-1) alive=1",
               hp, cnt_a, alive_a, W_A / (2 * hp));
    end
  endtask

  task automatic test_dead_osc();
    do_reset();
    run_cycles(0, 1, 0, 2 * W_A + 1);
    n_cmp++;
    if (cnt_a !== 16'd0 || alive_a !== 1'b0) begin
      n_err++;
      $display("FAIL dead_osc: count=%0d alive=%b, required 0/0", cnt_a, alive_a);
    end
  endtask

  task automatic test_random_osc();
    do_reset();
    run_cycles(0, 2, 0, 2 * W_A + 1);
    do_reset();
    run_cycles(1, 2, 0, 2 * W_B + 1);
  endtask

  task automatic test_reset_mid_window();
    do_reset();
    run_cycles(0, 0, 4, W_A + int'($urandom_range(10, W_A - 10)));
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (cnt_a !== 16'd0 || alive_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_window: count=%0d alive=%b, required 0/0", cnt_a, alive_a);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    n_cyc       = 0;
    hist.delete();
    last_cnt    = '0;
    last_alive  = 1'b0;
    osc_p_state = 1'b0;
    run_cycles(0, 0, 4, 2 * W_A + 1);
  endtask

  task automatic test_saturation();
    do_reset();
    run_cycles(1, 0, 2, 2 * W_B + 1);
    n_cmp++;
    if (cnt_b !== 4'd15 || alive_b !== 1'b1) begin
      n_err++;
      $display("FAIL saturation: count=%0d alive=%b, required 15/1", cnt_b, alive_b);
    end
  endtask

  task automatic test_edge_at_window_end();
    do_reset();
    run_cycles(1, 3, 0, W_B + 1);
    n_cmp++;
    if (cnt_b !== 4'd1 || alive_b !== 1'b1) begin
      n_err++;
      $display("FAIL edge_at_window_end: count=%0d alive=%b, required 1/1", cnt_b, alive_b);
    end
    run_cycles(1, 3, 0, W_B);
    n_cmp++;
    if (cnt_b !== 4'd0 || alive_b !== 1'b0) begin
      n_err++;
      $display("FAIL edge_next_window: count=%0d alive=%b, required 0/0", cnt_b, alive_b);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_cycles(0, 0, 3, W_A);
    run_cycles(0, 0, 6, W_A);
    run_cycles(0, 1, 0, W_A + 1);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    n_cyc       = 0;
    reset_n     = 1'b1;
    in_sig      = '0;
    osc_a       = 2'b10;
    osc_b       = 2'b10;
    osc_p_state = 1'b0;
    last_cnt    = '0;
    last_alive  = 1'b0;
    test_pass_through();
    test_differential();
    test_reset();
    test_frequency();
    test_dead_osc();
    test_random_osc();
    test_reset_mid_window();
    test_saturation();
    test_edge_at_window_end();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
